// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - synchronise/debounce three coin sensors, encode accepted coins into a small FIFO
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_10,
    input  logic             coin_20,
    input  logic             coin_50,
    output logic [1:0]       money,
    output logic             money_valid,
    input  logic             money_ready,
    output logic             reject,
    output logic             overflow,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0]       DB_MAX   = 8'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, QUAL, ACCEPT, WAIT_REL} state_t;

    logic [2:0]       sync_a;
    logic [2:0]       pat;
    state_t           state;
    logic [2:0]       latched;
    logic [7:0]       cnt;
    logic             one_hot;
    logic             multi;
    logic             pop;
    logic             push;
    logic [1:0]       code;
    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 3'b000;
            pat    <= 3'b000;
        end else begin
            sync_a <= {coin_50, coin_20, coin_10};
            pat    <= sync_a;
        end
    end

    assign one_hot = (pat != 3'b000) && ((pat & (pat - 3'd1)) == 3'b000);
    assign multi   = (pat != 3'b000) && !one_hot;
    assign code    = latched[2] ? 2'b10 : (latched[1] ? 2'b01 : 2'b00);

    assign money_valid = (fifo_count != '0);
    assign pop         = money_valid && money_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push        = (state == ACCEPT) && ((fifo_count != FULL_CNT) || pop);
    assign money       = money_valid ? mem[rd_ptr] : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            latched  <= 3'b000;
            cnt      <= 8'd0;
            reject   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            reject   <= 1'b0;
            overflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (one_hot) begin
                        latched <= pat;
                        cnt     <= 8'd1;
                        state   <= QUAL;
                    end else if (multi) begin
                        reject  <= 1'b1;
                        cnt     <= 8'd0;
                        state   <= WAIT_REL;
                    end
                end
                QUAL: begin
                    if (pat == latched) begin
                        if (cnt == DB_MAX) state <= ACCEPT;
                        else               cnt   <= cnt + 8'd1;
                    end else if (pat == 3'b000) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                    end else if (one_hot) begin
                        latched <= pat;
                        cnt     <= 8'd1;
                    end else begin
                        reject <= 1'b1;
                        cnt    <= 8'd0;
                        state  <= WAIT_REL;
                    end
                end
                ACCEPT: begin
                    overflow <= !push;
                    cnt      <= 8'd0;
                    state    <= WAIT_REL;
                end
                WAIT_REL: begin
                    // Lines must read idle for a full debounce window before rearming.
                    if (pat != 3'b000) begin
                        cnt <= 8'd0;
                    end else if (cnt == DB_MAX - 8'd1) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - vector table, corner sequences and randomized scoreboard for coin_acceptor
module tb_coin_acceptor;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin_10 = 1'b0;
    logic       coin_20 = 1'b0;
    logic       coin_50 = 1'b0;
    logic       money_ready = 1'b0;
    logic [1:0] money;
    logic       money_valid;
    logic       reject;
    logic       overflow;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;
    int rej_cnt = 0;
    int ovf_cnt = 0;
    int valid_cycles = 0;
    logic [1:0] last_money = 2'b00;

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .coin_10(coin_10), .coin_20(coin_20), .coin_50(coin_50),
        .money(money), .money_valid(money_valid), .money_ready(money_ready),
        .reject(reject), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            rej_cnt = rej_cnt + int'(reject);
            ovf_cnt = ovf_cnt + int'(overflow);
            if (money_valid) begin
                valid_cycles = valid_cycles + 1;
                last_money   = money;
            end
        end
    end

    typedef struct {
        logic [2:0] pat;
        int         hold;
        logic [1:0] exp_money;
        int         exp_push;
        int         exp_rej;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_raw(input logic [2:0] p);
        {coin_50, coin_20, coin_10} = p;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_raw(3'b000);
        money_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_coin(input logic [2:0] p, input int hold, input int gap);
        set_raw(p);
        repeat (hold) @(negedge clk);
        set_raw(3'b000);
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string name, input logic [1:0] e0, input logic [1:0] e1,
                         input logic [1:0] e2, input logic [1:0] e3);
        logic [1:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        money_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check({name, "_money"}, money, exp[i]);
            check({name, "_valid"}, money_valid, 1);
            @(posedge clk); #1;
        end
        check({name, "_empty"}, money_valid, 0);
        check({name, "_count0"}, fifo_count, 0);
        @(negedge clk);
        money_ready = 1'b0;
    endtask

    initial begin
        int r0, o0, v0;
        logic [1:0] q [$];
        logic [1:0] push_at [int];
        bit         rej_at [int];
        logic [7:0] exp_pack;
        logic [2:0] cur_pat;
        int         hold_left, gap_left, e;

        vecs[0] = '{3'b001, 10, 2'b00, 1, 0};
        vecs[1] = '{3'b010, 10, 2'b01, 1, 0};
        vecs[2] = '{3'b100, 10, 2'b10, 1, 0};
        vecs[3] = '{3'b100, 3,  2'b00, 0, 0};
        vecs[4] = '{3'b010, D,  2'b00, 0, 0};
        vecs[5] = '{3'b010, D+1, 2'b01, 1, 0};
        vecs[6] = '{3'b011, 8,  2'b00, 0, 1};
        vecs[7] = '{3'b111, 6,  2'b00, 0, 1};
        vecs[8] = '{3'b101, 1,  2'b00, 0, 1};

        #1;
        check("rst_valid", money_valid, 0);
        check("rst_money", money, 0);
        check("rst_count", fifo_count, 0);
        check("rst_reject", reject, 0);
        check("rst_overflow", overflow, 0);

        // Vector table: isolated single events with the consumer always ready
        for (int i = 0; i < 9; i++) begin
            do_reset();
            money_ready = 1'b1;
            r0 = rej_cnt; v0 = valid_cycles;
            run_coin(vecs[i].pat, vecs[i].hold, 12);
            check($sformatf("vec%0d_push", i), valid_cycles - v0, vecs[i].exp_push);
            check($sformatf("vec%0d_rej", i), rej_cnt - r0, vecs[i].exp_rej);
            if (vecs[i].exp_push != 0) check($sformatf("vec%0d_money", i), last_money, vecs[i].exp_money);
            check($sformatf("vec%0d_count", i), fifo_count, 0);
        end

        // Exact latency of a clean coin
        do_reset();
        money_ready = 1'b1;
        r0 = rej_cnt;
        set_raw(3'b010);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 7) check("lat_e7_valid", money_valid, 0);
            if (i == 8) begin
                check("lat_e8_valid", money_valid, 1);
                check("lat_e8_money", money, 2'b01);
                check("lat_e8_count", fifo_count, 1);
            end
            if (i == 9) begin
                check("lat_e9_valid", money_valid, 0);
                check("lat_e9_count", fifo_count, 0);
            end
        end
        @(negedge clk);
        run_coin(3'b000, 0, 8);
        check("lat_reject", rej_cnt - r0, 0);

        // Back-pressure and overflow
        do_reset();
        o0 = ovf_cnt; r0 = rej_cnt;
        run_coin(3'b001, 10, 8);
        run_coin(3'b010, 10, 8);
        run_coin(3'b100, 10, 8);
        run_coin(3'b001, 10, 8);
        check("bp_count4", fifo_count, 4);
        check("bp_head", money, 2'b00);
        check("bp_no_ovf_yet", ovf_cnt - o0, 0);
        run_coin(3'b010, 10, 8);
        check("bp_ovf_pulse", ovf_cnt - o0, 1);
        check("bp_count_stays", fifo_count, 4);
        check("bp_no_reject", rej_cnt - r0, 0);
        drain("bp_drain", 2'b00, 2'b01, 2'b10, 2'b00);

        // Full FIFO with a pop in the accept cycle
        do_reset();
        o0 = ovf_cnt;
        run_coin(3'b001, 10, 8);
        run_coin(3'b010, 10, 8);
        run_coin(3'b100, 10, 8);
        run_coin(3'b001, 10, 8);
        set_raw(3'b100);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 7) begin
                check("sim_e7_count", fifo_count, 4);
                money_ready = 1'b1;
            end
            if (i == 8) begin
                check("sim_e8_count", fifo_count, 4);
                check("sim_e8_ovf", overflow, 0);
                money_ready = 1'b0;
            end
        end
        @(negedge clk);
        run_coin(3'b000, 0, 8);
        check("sim_no_ovf", ovf_cnt - o0, 0);
        drain("sim_drain", 2'b01, 2'b10, 2'b00, 2'b10);

        // Asynchronous reset in the middle of qualification
        do_reset();
        run_coin(3'b001, 10, 8);
        run_coin(3'b100, 10, 8);
        check("ar_count2", fifo_count, 2);
        set_raw(3'b010);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("ar_count", fifo_count, 0);
        check("ar_valid", money_valid, 0);
        check("ar_money", money, 0);
        check("ar_rej_ovf", {reject, overflow}, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (i == 7) check("ar_e7_valid", money_valid, 0);
            if (i == 8) begin
                check("ar_e8_valid", money_valid, 1);
                check("ar_e8_money", money, 2'b01);
                check("ar_e8_count", fifo_count, 1);
            end
        end
        @(negedge clk);
        set_raw(3'b000);

        // Randomized events against a timestamp/queue scoreboard
        do_reset();
        hold_left = 0; gap_left = 0; e = 1; cur_pat = 3'b000;
        exp_pack = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            check("rand_cycle", {money_valid, money, fifo_count, reject, overflow}, exp_pack);

            if (hold_left == 0 && gap_left == 0) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 7) cur_pat = 3'b001 << $urandom_range(0, 2);
                else       cur_pat = (r == 7) ? 3'b011 : ((r == 8) ? 3'b101 : (($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111));
                hold_left = $urandom_range(1, 10);
                gap_left  = $urandom_range(D + 2, D + 8);
                if (cur_pat == 3'b001 || cur_pat == 3'b010 || cur_pat == 3'b100) begin
                    if (hold_left >= D + 1)
                        push_at[e + D + 3] = (cur_pat == 3'b001) ? 2'b00 : ((cur_pat == 3'b010) ? 2'b01 : 2'b10);
                end else begin
                    rej_at[e + 2] = 1'b1;
                end
            end
            if (hold_left > 0) begin
                set_raw(cur_pat);
                hold_left--;
            end else begin
                set_raw(3'b000);
                gap_left--;
            end
            if (((e / 64) % 2) == 1) money_ready = ($urandom_range(0, 1) == 0);
            else                     money_ready = ($urandom_range(0, 7) == 0);

            begin
                bit pop_m, ovf_m, rej_m;
                pop_m = (q.size() > 0) && money_ready;
                ovf_m = 1'b0;
                if (pop_m) void'(q.pop_front());
                if (push_at.exists(e)) begin
                    if (q.size() < DEPTH) q.push_back(push_at[e]);
                    else                  ovf_m = 1'b1;
                end
                rej_m = rej_at.exists(e);
                exp_pack = {(q.size() > 0) ? 1'b1 : 1'b0,
                            (q.size() > 0) ? q[0] : 2'b00,
                            3'(q.size()), rej_m, ovf_m};
            end
            e++;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage of the vending datapath. It synchronises and debounces three raw coin-sensor lines (Rs10, Rs20, Rs50) and rejects multi-coin or glitch events. Each accepted coin is encoded into the 2-bit money code (ten=00, twenty=01, fifty=10) and buffered in a small FIFO. The downstream vending FSM drains the FIFO through a valid/ready handshake and advances only on a transfer.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to qualify a coin, and later to qualify release; range 2..255
FIFO_DEPTH, 4, coin buffer entries; power of two, 2..16
CNT_W, 3, width of fifo_count; must hold FIFO_DEPTH (log2(FIFO_DEPTH)+1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
coin_10  input  1  raw Rs10 sensor, asynchronous to clk, high while coin present
coin_20  input  1  raw Rs20 sensor, asynchronous
coin_50  input  1  raw Rs50 sensor, asynchronous
money  output  2  head-of-FIFO coin code: 00=10, 01=20, 10=50; 11 never driven
money_valid  output  1  FIFO non-empty
money_ready  input  1  downstream accepts head entry this cycle
reject  output  1  one-cycle pulse: multi-line coin event discarded
overflow  output  1  one-cycle pulse: qualified coin dropped, FIFO full
fifo_count  output  CNT_W  entries currently buffered

Behaviour:
- Reset (reset=0, async): synchronisers 0, FSM IDLE, debounce counter 0, FIFO empty, money=00, money_valid=0, reject=0, overflow=0, fifo_count=0. Reset mid-qualification discards the coin in progress. Release is synchronous to clk.
- Sync: 2-flop synchroniser per line. The FSM sees only the synchronised 3-bit pattern P.
- FSM states: IDLE, QUAL, ACCEPT, WAIT_REL.
- IDLE: P==000, stay. P one-hot: latch P, cnt=1, go QUAL. P multi-bit: reject=1 next cycle, go WAIT_REL.
- QUAL: P equals latched pattern and cnt<DEBOUNCE_CYCLES: cnt++. P equals latched and cnt==DEBOUNCE_CYCLES: go ACCEPT. P==000: glitch, go IDLE, no push, no pulse. P a different one-hot: re-latch, cnt=1. P multi-bit: reject pulse, go WAIT_REL.
- ACCEPT (exactly 1 cycle): push the encoded latched coin, then go WAIT_REL with cnt=0.
- WAIT_REL: P==000 for DEBOUNCE_CYCLES consecutive cycles, then go IDLE. Any nonzero P clears cnt. A held coin therefore counts once only.
- Latency: raw line rises before edge 1 and stays stable. money_valid rises right after edge DEBOUNCE_CYCLES+4 (edge 8 for the default), with FIFO previously empty.
- FIFO:
  - Circular buffer with wrapping read/write pointers; fifo_count registered.
  - Push when in ACCEPT and (count<FIFO_DEPTH or pop this cycle).
  - ACCEPT with count==FIFO_DEPTH and no pop: coin dropped, overflow=1 for one cycle, pointers unchanged.
  - Pop when money_valid && money_ready.
  - Simultaneous push and pop: both occur, count unchanged (including when full and when count==1).
  - money_ready while empty: ignored.
- Output rules:
  - money is combinational from the head entry; it reads 00 when empty.
  - money and money_valid stay stable while money_valid && !money_ready.
  - reject and overflow are registered pulses and never both high.

Test Plan:
- Clean Rs20: coin_20 high 10 cycles, ready=1 → money_valid high exactly 1 cycle at edge 8 with money=01; fifo_count 0→1→0; no reject.
- Glitch: coin_50 high 3 cycles (D=4) → no push, no reject, FSM back to IDLE; a following 10-cycle coin_50 → money=10 accepted once.
- Multi-coin: coin_10 and coin_20 high together for 8 cycles → reject pulses once, no FIFO entry; FSM returns to IDLE 4 cycles after both lines fall.
- Back-pressure/overflow:
  - Setup: ready=0; insert coins in order 10, 20, 50, 10, 20.
  - First 4 buffered: money=00, count=4.
  - 5th coin: overflow pulse, count stays 4.
  - Then ready=1: outputs 00, 01, 10, 00 on consecutive cycles, then valid=0.
- Simultaneous: FIFO full, ready=1 in the ACCEPT cycle → no overflow, count stays 4, new coin appears last in drain order.
- Async reset: assert reset=0 mid-QUAL with count=2 → all outputs 0 immediately without a clock; after release the held coin is re-qualified from IDLE.
